// File: rtl/fc_trigger_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fc_trigger_sequencer
// Description : Merges prescaled trigger sources into one L1A stream, applies
//               deadtime and busy vetoes, builds the fast-control word with
//               BCR / L1A / link-reset / buffer-clear bits and emits its
//               Hamming(8,4)-encoded form plus accept/veto statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module fc_trigger_sequencer #(
    parameter int NUM_SRC    = 4,
    parameter int PRESCALE_W = 16,
    parameter int ORBIT_W    = 12,
    parameter int VETO_W     = 12
) (
    input  logic                          clk_bx,
    input  logic                          reset,
    input  logic [NUM_SRC-1:0]            trig_in,
    input  logic [NUM_SRC-1:0]            src_enable,
    input  logic [NUM_SRC*PRESCALE_W-1:0] src_prescale,
    input  logic [ORBIT_W-1:0]            orb_length,
    input  logic [VETO_W-1:0]             l1a_veto_len,
    input  logic                          daq_busy,
    input  logic                          occ_busy,
    input  logic                          enable_veto_busy,
    input  logic                          send_link_reset,
    input  logic                          send_buffer_clear,
    input  logic                          counter_clear,
    output logic [7:0]                    fc_word,
    output logic [15:0]                   fc_stream_enc,
    output logic [ORBIT_W-1:0]            bx_counter,
    output logic [NUM_SRC-1:0]            l1a_src,
    output logic [31:0]                   accepted_count,
    output logic [15:0]                   vetoed_count
);

    // Hamming(8,4): {d3,d2,d1,d0,p3,p2,p1,p0}, p0 is overall parity
    function automatic logic [7:0] hamming84(input logic [3:0] d);
        logic p1;
        logic p2;
        logic p3;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p3 = d[1] ^ d[2] ^ d[3];
        return {d, p3, p2, p1, ^{d, p3, p2, p1}};
    endfunction

    logic [NUM_SRC-1:0] w_pass;
    logic               w_cand;
    logic               w_veto;
    logic               w_accept;
    logic [VETO_W-1:0]  r_dt;
    logic               r_pend_lr;
    logic               r_pend_bc;
    logic               w_cmd_lr;
    logic               w_cmd_bc;
    logic [ORBIT_W-1:0] r_bx;
    logic               w_bx_wrap;
    logic [7:0]         r_fc_word;
    logic [NUM_SRC-1:0] r_l1a_src;
    logic [15:0]        r_fc_enc;
    logic [31:0]        r_acc;
    logic [15:0]        r_vet;

    // Per-source prescaler: counter reloads on a passing pulse, else counts down
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [PRESCALE_W-1:0] r_pc;
        logic [PRESCALE_W-1:0] w_p;

        assign w_p       = src_prescale[i*PRESCALE_W +: PRESCALE_W];
        assign w_pass[i] = trig_in[i] && src_enable[i] && (r_pc == '0);

        // Disabled sources are held at zero so they pass on their first pulse
        always_ff @(posedge clk_bx) begin
            if (reset || !src_enable[i]) begin
                r_pc <= '0;
            end else if (trig_in[i]) begin
                r_pc <= (r_pc == '0) ? w_p : r_pc - PRESCALE_W'(1);
            end
        end
    end

    assign w_cand   = |w_pass;
    assign w_veto   = (r_dt != '0) || occ_busy || (daq_busy && enable_veto_busy);
    assign w_accept = w_cand && !w_veto;

    // Commands are emitted only in non-accept cycles; a new request merges into a pending one
    assign w_cmd_lr = !w_accept && (r_pend_lr || send_link_reset);
    assign w_cmd_bc = !w_accept && (r_pend_bc || send_buffer_clear);

    // Compare against orb_length-1 so lowering the orbit below the count still wraps
    assign w_bx_wrap = (orb_length <= ORBIT_W'(1)) || (r_bx >= orb_length - ORBIT_W'(1));

    // Deadtime counter: loads on accept, drains to zero otherwise
    always_ff @(posedge clk_bx) begin
        if (reset) begin
            r_dt <= '0;
        end else if (w_accept) begin
            r_dt <= l1a_veto_len;
        end else if (r_dt != '0) begin
            r_dt <= r_dt - VETO_W'(1);
        end
    end

    // Pending command flags survive accept cycles and clear once emitted
    always_ff @(posedge clk_bx) begin
        if (reset) begin
            r_pend_lr <= 1'b0;
            r_pend_bc <= 1'b0;
        end else begin
            r_pend_lr <= w_accept && (r_pend_lr || send_link_reset);
            r_pend_bc <= w_accept && (r_pend_bc || send_buffer_clear);
        end
    end

    // Bunch-crossing counter within the orbit
    always_ff @(posedge clk_bx) begin
        if (reset) begin
            r_bx <= '0;
        end else if (w_bx_wrap) begin
            r_bx <= '0;
        end else begin
            r_bx <= r_bx + ORBIT_W'(1);
        end
    end

    // Fast-control word and source map, then the encoded stream one cycle later
    always_ff @(posedge clk_bx) begin
        if (reset) begin
            r_fc_word <= 8'h00;
            r_l1a_src <= '0;
            r_fc_enc  <= 16'h0000;
        end else begin
            r_fc_word <= {4'b0000, w_cmd_bc, w_cmd_lr, w_accept, (r_bx == '0)};
            r_l1a_src <= w_accept ? w_pass : '0;
            r_fc_enc  <= {hamming84(r_fc_word[7:4]), hamming84(r_fc_word[3:0])};
        end
    end

    // Statistics: clear wins over increment; veto count saturates
    always_ff @(posedge clk_bx) begin
        if (reset || counter_clear) begin
            r_acc <= 32'd0;
            r_vet <= 16'd0;
        end else begin
            if (w_accept) begin
                r_acc <= r_acc + 32'd1;
            end
            if (w_cand && w_veto && (r_vet != 16'hFFFF)) begin
                r_vet <= r_vet + 16'd1;
            end
        end
    end

    assign fc_word        = r_fc_word;
    assign fc_stream_enc  = r_fc_enc;
    assign bx_counter     = r_bx;
    assign l1a_src        = r_l1a_src;
    assign accepted_count = r_acc;
    assign vetoed_count   = r_vet;

endmodule
`default_nettype wire

// File: tb/tb_fc_trigger_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fc_trigger_sequencer
// Description : Self-checking bench for fc_trigger_sequencer: directed vector
//               table, hand-written corner sequences and randomized stimulus
//               against a cycle-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fc_trigger_sequencer;

    localparam int NS = 4;
    localparam int PW = 16;
    localparam int OW = 12;
    localparam int VW = 12;

    logic           clk_bx = 1'b0;
    logic           reset;
    logic [NS-1:0]  trig_in;
    logic [NS-1:0]  src_enable;
    logic [NS*PW-1:0] src_prescale;
    logic [OW-1:0]  orb_length;
    logic [VW-1:0]  l1a_veto_len;
    logic           daq_busy;
    logic           occ_busy;
    logic           enable_veto_busy;
    logic           send_link_reset;
    logic           send_buffer_clear;
    logic           counter_clear;
    logic [7:0]     fc_word;
    logic [15:0]    fc_stream_enc;
    logic [OW-1:0]  bx_counter;
    logic [NS-1:0]  l1a_src;
    logic [31:0]    accepted_count;
    logic [15:0]    vetoed_count;

    always #5 clk_bx = ~clk_bx;

    fc_trigger_sequencer #(
        .NUM_SRC(NS), .PRESCALE_W(PW), .ORBIT_W(OW), .VETO_W(VW)
    ) dut (
        .clk_bx(clk_bx), .reset(reset), .trig_in(trig_in), .src_enable(src_enable),
        .src_prescale(src_prescale), .orb_length(orb_length), .l1a_veto_len(l1a_veto_len),
        .daq_busy(daq_busy), .occ_busy(occ_busy), .enable_veto_busy(enable_veto_busy),
        .send_link_reset(send_link_reset), .send_buffer_clear(send_buffer_clear),
        .counter_clear(counter_clear), .fc_word(fc_word), .fc_stream_enc(fc_stream_enc),
        .bx_counter(bx_counter), .l1a_src(l1a_src), .accepted_count(accepted_count),
        .vetoed_count(vetoed_count)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b1;

    // Reference model state
    int            m_pc[NS];
    int            m_dead;
    bit            m_plr;
    bit            m_pbc;
    int            m_bx;
    logic [31:0]   m_acc;
    int            m_vet;
    logic [7:0]    m_fc;
    logic [NS-1:0] m_src;
    logic [15:0]   m_enc;

    typedef struct {
        logic [NS-1:0] trig;
        logic          lr;
        logic          bc;
        logic [7:0]    exp_fc;
        logic [NS-1:0] exp_src;
        logic [15:0]   exp_enc;
    } vec_t;

    // Generator-matrix rows of the Hamming(8,4) code, one per data bit
    function automatic logic [7:0] g_row(input int i);
        case (i)
            0:       return 8'h17;
            1:       return 8'h2B;
            2:       return 8'h4D;
            default: return 8'h8E;
        endcase
    endfunction

    function automatic logic [7:0] ham(input logic [3:0] d);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < 4; i++) if (d[i]) c = c ^ g_row(i);
        return c;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        logic [NS-1:0] passed;
        bit veto, acc_now, lr, bc;
        int p;
        if (reset) begin
            for (int i = 0; i < NS; i++) m_pc[i] = 0;
            m_dead = 0; m_plr = 0; m_pbc = 0; m_bx = 0; m_acc = 0; m_vet = 0;
            m_fc = 8'h00; m_src = '0; m_enc = 16'h0000;
            return;
        end
        m_enc = {ham(m_fc[7:4]), ham(m_fc[3:0])};
        passed = '0;
        for (int i = 0; i < NS; i++) begin
            p = src_prescale[i*PW +: PW];
            if (!src_enable[i]) m_pc[i] = 0;
            else if (trig_in[i]) begin
                if (m_pc[i] == 0) begin
                    passed[i] = 1'b1;
                    m_pc[i] = p;
                end else m_pc[i] = m_pc[i] - 1;
            end
        end
        veto    = (m_dead > 0) || occ_busy || (daq_busy && enable_veto_busy);
        acc_now = (passed != '0) && !veto;
        lr      = !acc_now && (m_plr || send_link_reset);
        bc      = !acc_now && (m_pbc || send_buffer_clear);
        m_plr   = acc_now && (m_plr || send_link_reset);
        m_pbc   = acc_now && (m_pbc || send_buffer_clear);
        m_fc    = {4'b0000, bc, lr, acc_now, (m_bx == 0)};
        m_src   = acc_now ? passed : '0;
        m_dead  = acc_now ? int'(l1a_veto_len) : ((m_dead > 0) ? m_dead - 1 : 0);
        m_bx    = (orb_length <= 1 || m_bx >= int'(orb_length) - 1) ? 0 : m_bx + 1;
        if (counter_clear) begin
            m_acc = 0;
            m_vet = 0;
        end else begin
            if (acc_now) m_acc = m_acc + 1;
            if ((passed != '0) && veto && m_vet < 65535) m_vet = m_vet + 1;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_bx);
        #1;
        if (cmp_en) begin
            chk("model_fc_word", fc_word, m_fc);
            chk("model_l1a_src", l1a_src, m_src);
            chk("model_fc_stream_enc", fc_stream_enc, m_enc);
            chk("model_bx_counter", bx_counter, 64'(m_bx));
            chk("model_accepted_count", accepted_count, m_acc);
            chk("model_vetoed_count", vetoed_count, 64'(m_vet));
        end
    endtask

    task automatic set_idle();
        trig_in = '0; send_link_reset = 0; send_buffer_clear = 0; counter_clear = 0;
        daq_busy = 0; occ_busy = 0;
    endtask

    task automatic set_prescale_all(input int p);
        for (int i = 0; i < NS; i++) src_prescale[i*PW +: PW] = PW'(p);
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    vec_t tbl[13];

    initial begin
        bit found;
        reset = 1; enable_veto_busy = 1; src_enable = '1; orb_length = 12'd1000;
        l1a_veto_len = 12'd3; set_prescale_all(0); set_idle();

        // Reset state
        do_reset();
        chk("reset_fc_word", fc_word, 8'h00);
        chk("reset_enc", fc_stream_enc, 16'h0000);
        chk("reset_bx", bx_counter, 0);
        tick();
        chk("first_edge_bcr", fc_word, 8'h01);
        chk("first_edge_bx", bx_counter, 1);

        // Deadtime and command collision vector table (veto_len=3)
        tbl[0]  = '{4'b0010, 0, 0, 8'h02, 4'b0010, 16'h0017};
        tbl[1]  = '{4'b0000, 0, 0, 8'h00, 4'b0000, 16'h002B};
        tbl[2]  = '{4'b0010, 0, 0, 8'h00, 4'b0000, 16'h0000};
        tbl[3]  = '{4'b0000, 0, 0, 8'h00, 4'b0000, 16'h0000};
        tbl[4]  = '{4'b0010, 0, 0, 8'h02, 4'b0010, 16'h0000};
        tbl[5]  = '{4'b0000, 0, 0, 8'h00, 4'b0000, 16'h002B};
        tbl[6]  = '{4'b0000, 0, 0, 8'h00, 4'b0000, 16'h0000};
        tbl[7]  = '{4'b0000, 0, 0, 8'h00, 4'b0000, 16'h0000};
        tbl[8]  = '{4'b0001, 0, 1, 8'h02, 4'b0001, 16'h0000};
        tbl[9]  = '{4'b0000, 0, 0, 8'h08, 4'b0000, 16'h002B};
        tbl[10] = '{4'b0000, 1, 0, 8'h04, 4'b0000, 16'h008E};
        tbl[11] = '{4'b0000, 1, 1, 8'h0C, 4'b0000, 16'h004D};
        tbl[12] = '{4'b0000, 0, 0, 8'h00, 4'b0000, 16'h00C3};
        for (int r = 0; r < 13; r++) begin
            trig_in = tbl[r].trig;
            send_link_reset = tbl[r].lr;
            send_buffer_clear = tbl[r].bc;
            tick();
            chk($sformatf("tbl%0d_fc_word", r), fc_word, tbl[r].exp_fc);
            chk($sformatf("tbl%0d_l1a_src", r), l1a_src, tbl[r].exp_src);
            chk($sformatf("tbl%0d_enc", r), fc_stream_enc, tbl[r].exp_enc);
        end
        set_idle();
        chk("deadtime_accepted", accepted_count, 3);
        chk("deadtime_vetoed", vetoed_count, 1);

        // Prescale: p=2 on source 0, nine pulses spaced 5 bx
        src_enable = 4'b0001; set_prescale_all(2); l1a_veto_len = 0;
        do_reset();
        for (int k = 0; k < 9; k++) begin
            trig_in = 4'b0001;
            tick();
            chk($sformatf("prescale_pulse%0d", k + 1), fc_word[1], (k % 3) == 0);
            trig_in = '0;
            repeat (4) tick();
        end
        chk("prescale_accepted", accepted_count, 3);
        chk("prescale_vetoed", vetoed_count, 0);

        // Orbit wrap and BCR
        orb_length = 12'd45;
        do_reset();
        for (int k = 0; k < 100; k++) begin
            tick();
            chk($sformatf("bcr45_k%0d", k), fc_word[0], (k % 45) == 0);
        end
        found = 0;
        for (int k = 0; k < 60 && !found; k++) begin
            if (bx_counter == 30) found = 1;
            else tick();
        end
        chk("wait_bx30", found, 1);
        orb_length = 12'd10;
        tick();
        chk("orb_shrink_bx", bx_counter, 0);
        orb_length = 12'd1;
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("orb1_bcr", fc_word[0], 1);
            chk("orb1_bx", bx_counter, 0);
        end
        orb_length = 12'd0;
        tick();
        chk("orb0_bx", bx_counter, 0);
        orb_length = 12'd1000;

        // Saturation of the veto counter and clear priority
        src_enable = 4'b0001; set_prescale_all(0);
        do_reset();
        occ_busy = 1; trig_in = 4'b0001;
        cmp_en = 0;
        repeat (70000) tick();
        cmp_en = 1;
        chk("sat_vetoed", vetoed_count, 16'hFFFF);
        chk("sat_accepted", accepted_count, 0);
        counter_clear = 1;
        tick();
        chk("clear_priority", vetoed_count, 0);
        counter_clear = 0;
        tick();
        chk("after_clear", vetoed_count, 1);
        set_idle();

        // Reset mid-deadtime with a link reset pending
        src_enable = '1; l1a_veto_len = 12'd5;
        do_reset();
        tick();
        trig_in = 4'b0001; send_link_reset = 1;
        tick();
        chk("midop_accept", fc_word, 8'h02);
        set_idle();
        reset = 1;
        tick();
        chk("midop_reset_fc", fc_word, 8'h00);
        chk("midop_reset_src", l1a_src, 0);
        chk("midop_reset_enc", fc_stream_enc, 16'h0000);
        chk("midop_reset_acc", accepted_count, 0);
        reset = 0; trig_in = 4'b0001;
        tick();
        chk("post_reset_accept", fc_word, 8'h03);
        trig_in = '0;
        tick();
        chk("no_stale_link_reset", fc_word, 8'h00);

        // Randomized stimulus against the model
        for (int c = 0; c < 2500; c++) begin
            if (c % 200 == 0) begin
                src_enable = NS'($urandom);
                for (int i = 0; i < NS; i++) src_prescale[i*PW +: PW] = PW'($urandom_range(0, 3));
                orb_length = OW'($urandom_range(0, 60));
                l1a_veto_len = VW'($urandom_range(0, 4));
                enable_veto_busy = 1'($urandom);
            end
            for (int i = 0; i < NS; i++) trig_in[i] = ($urandom_range(0, 2) == 0);
            occ_busy          = ($urandom_range(0, 9) == 0);
            daq_busy          = ($urandom_range(0, 3) == 0);
            send_link_reset   = ($urandom_range(0, 7) == 0);
            send_buffer_clear = ($urandom_range(0, 7) == 0);
            counter_clear     = ($urandom_range(0, 99) == 0);
            reset             = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 0;
        set_idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
